// File: rtl/internal_pin_if_status_in.sv
// Avalon-MM status input port for the internal pin interface.
// Synchronizes an asynchronous status bus into clk, latches selected edges
// into a sticky capture register and drives a maskable level interrupt.
module internal_pin_if_status_in #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] detect_vec;
  logic [WIDTH-1:0] clear_vec;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  assign wr_en   = chipselect & ~write_n;
  assign data_in = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; the last stage is the clk-domain view of in_port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Edge selection and clear vector for the capture register.
  always_comb begin
    detect_vec = '0;
    case (EDGE_TYPE)
      0:       detect_vec = data_in & ~prev_q;
      1:       detect_vec = ~data_in & prev_q;
      default: detect_vec = data_in ^ prev_q;
    endcase

    clear_vec = '0;
    if (wr_en && address == ADDR_EDGE) begin
      if (BIT_CLEAR != 0) clear_vec = writedata[WIDTH-1:0];
      else                clear_vec = '1;
    end

    // A new edge overrides a simultaneous clear so no event is lost.
    edge_capture_d = (edge_capture_q & ~clear_vec) | detect_vec;

    irq_mask_d = irq_mask_q;
    if (wr_en && address == ADDR_MASK) irq_mask_d = writedata[WIDTH-1:0];
  end

  // Read mux; sampled every edge so reads are side-effect free.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = data_in;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
      default:   readdata_d = '0;
    endcase
  end

  // Edge history, capture, mask and read data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q         <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= '0;
      readdata_q     <= '0;
    end else begin
      prev_q         <= data_in;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_internal_pin_if_status_in.sv
// Directed bench: instance A uses defaults (rising, W1C, 32 bits);
// instance B uses falling edges, clear-all writes and an 8-bit port.
module tb_internal_pin_if_status_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs_a, cs_b;
  logic [31:0] in_a;
  logic [7:0]  in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;
  logic [31:0] rv;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  internal_pin_if_status_in u_dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  internal_pin_if_status_in #(.WIDTH(8), .EDGE_TYPE(1), .BIT_CLEAR(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    cs_a = !sel_b; cs_b = sel_b;
    @(posedge clk); #1;
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input bit sel_b, input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk); #1;
    d = sel_b ? rd_b : rd_a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0;
    cs_a = 1'b0; cs_b = 1'b0; in_a = '0; in_b = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_a", rd_a, 32'h0);
    chk("rst_irq_a", {31'b0, irq_a}, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    bus_rd(0, 2'd0, rv); chk("a_rd0", rv, 32'h0);
    bus_rd(0, 2'd1, rv); chk("a_rd1", rv, 32'h0);
    bus_rd(0, 2'd2, rv); chk("a_rd2", rv, 32'h0);
    bus_rd(0, 2'd3, rv); chk("a_rd3", rv, 32'h0);
    chk("a_irq_idle", {31'b0, irq_a}, 32'h0);

    // Capture latency: edge_capture valid after k+2, readdata one edge later
    @(negedge clk); address = 2'd3; in_a = 32'h0000_00A5;
    repeat (3) @(posedge clk);
    #1 chk("a_cap_lat_k2", rd_a, 32'h0);
    @(posedge clk); #1 chk("a_cap_lat_k3", rd_a, 32'h0000_00A5);
    chk("a_irq_masked", {31'b0, irq_a}, 32'h0);

    bus_rd(0, 2'd0, rv); chk("a_data", rv, 32'h0000_00A5);
    bus_wr(0, 2'd0, 32'h1234_5678);
    bus_rd(0, 2'd0, rv); chk("a_data_ro", rv, 32'h0000_00A5);
    bus_wr(0, 2'd1, 32'hFFFF_FFFF);
    bus_rd(0, 2'd1, rv); chk("a_resv", rv, 32'h0);

    bus_wr(0, 2'd2, 32'h0000_0004);
    chk("a_irq_mask_on", {31'b0, irq_a}, 32'h1);
    bus_rd(0, 2'd2, rv); chk("a_mask_rd", rv, 32'h0000_0004);

    bus_wr(0, 2'd3, 32'h0000_0001);
    chk("a_irq_after_w1c1", {31'b0, irq_a}, 32'h1);
    bus_rd(0, 2'd3, rv); chk("a_w1c1", rv, 32'h0000_00A4);
    bus_wr(0, 2'd3, 32'h0000_0004);
    chk("a_irq_after_w1c4", {31'b0, irq_a}, 32'h0);
    bus_rd(0, 2'd3, rv); chk("a_w1c4", rv, 32'h0000_00A0);

    bus_wr(0, 2'd3, 32'h0000_0020);
    chk("a_preclear_rd", rd_a, 32'h0000_00A0);
    bus_rd(0, 2'd3, rv); chk("a_w1c20", rv, 32'h0000_0080);

    // Bit 3 rises; its detect cycle coincides with a W1C of bit 3
    @(negedge clk); in_a = 32'h0000_00AD;
    @(posedge clk); @(posedge clk);
    bus_wr(0, 2'd3, 32'h0000_0008);
    bus_rd(0, 2'd3, rv); chk("a_edge_wins", rv, 32'h0000_0088);
    bus_wr(0, 2'd3, 32'h0000_0008);
    bus_rd(0, 2'd3, rv); chk("a_w1c8", rv, 32'h0000_0080);

    // Instance B: falling edges, clear-all, 8-bit
    bus_rd(1, 2'd3, rv); chk("b_no_rise_cap", rv, 32'h0);
    bus_rd(1, 2'd0, rv); chk("b_data", rv, 32'h0000_00FF);
    @(negedge clk); in_b = 8'h0F;
    repeat (3) @(posedge clk);
    bus_rd(1, 2'd3, rv); chk("b_fall_cap", rv, 32'h0000_00F0);
    chk("b_irq_masked", {31'b0, irq_b}, 32'h0);
    bus_wr(1, 2'd2, 32'hFFFF_FF10);
    chk("b_irq_on", {31'b0, irq_b}, 32'h1);
    bus_rd(1, 2'd2, rv); chk("b_mask_zext", rv, 32'h0000_0010);
    bus_wr(1, 2'd3, 32'h0000_0001);
    chk("b_irq_clr", {31'b0, irq_b}, 32'h0);
    bus_rd(1, 2'd3, rv); chk("b_clear_all", rv, 32'h0);

    // Asynchronous reset mid-operation on A
    bus_wr(0, 2'd2, 32'h0000_00FF);
    chk("a_irq_pre_rst", {31'b0, irq_a}, 32'h1);
    @(posedge clk); #3;
    reset_n = 1'b0; in_a = 32'h0000_0001;
    #1;
    chk("a_async_irq", {31'b0, irq_a}, 32'h0);
    chk("a_async_rd", rd_a, 32'h0);
    repeat (2) @(posedge clk);

    @(negedge clk);
    reset_n = 1'b1; address = 2'd2; writedata = 32'h0000_0001;
    write_n = 1'b0; cs_a = 1'b1;
    @(posedge clk); #1;
    cs_a = 1'b0; write_n = 1'b1; address = 2'd3;
    chk("a_rel_e1_irq", {31'b0, irq_a}, 32'h0);
    @(posedge clk); #1 chk("a_rel_e2_irq", {31'b0, irq_a}, 32'h0);
    @(posedge clk); #1 chk("a_rel_e3_irq", {31'b0, irq_a}, 32'h1);
    chk("a_rel_e3_rd", rd_a, 32'h0);
    @(posedge clk); #1 chk("a_rel_e4_rd", rd_a, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/internal_pin_if_status_in.md
Name: internal_pin_if_status_in

Overview:
- Avalon-MM slave input port: the read-side counterpart of the internal pin interface's parameter output registers.
- Samples a 32-bit status bus from fabric logic into the clk domain and captures per-bit edges into a sticky register.
- Raises a maskable level interrupt so the host CPU can read status instead of polling.
- Sits on the same internal pin interface bus as the parameter output registers.

Parameters:
- WIDTH, 32, width of in_port and of every register (1..32); unused readdata bits read 0.
- SYNC_STAGES, 2, flip-flop synchronizer depth on in_port (2..4).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- BIT_CLEAR, 1, 1 = edge register is write-1-to-clear per bit; 0 = any write to address 3 clears all bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous status inputs
- readdata  out  32  registered read data, fixed read latency 1
- irq  out  1  level interrupt, active high

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All of the following clear to 0 immediately on assertion: synchronizer stages, prev register, edge_capture, irq_mask, readdata. irq goes 0.
- Synchronizer: in_port passes through SYNC_STAGES flops; the last stage is data_in.
  - With SYNC_STAGES=2, a value stable at edge k appears on data_in after edge k+1.
- Edge detect:
  - prev <= data_in every cycle.
  - rise = data_in & ~prev; fall = ~data_in & prev; any = rise | fall. EDGE_TYPE selects which.
  - edge_capture bit sets on the edge after detection, i.e. edge k+2 for SYNC_STAGES=2.
- Register map:
  - Addr 0 data: read-only, returns data_in zero-extended; writes ignored.
  - Addr 1: reserved, reads 0, writes ignored.
  - Addr 2 irq_mask: read/write, WIDTH bits; write takes effect the edge of the write.
  - Addr 3 edge_capture: readable; clear per BIT_CLEAR.
- Write strobe: a write is chipselect & ~write_n at a rising clk edge.
- edge_capture update, each edge: edge_capture <= (edge_capture & ~clear_vec) | detect_vec.
  - BIT_CLEAR=1: clear_vec = writedata[WIDTH-1:0] when writing addr 3, else 0.
  - BIT_CLEAR=0: clear_vec = all ones when writing addr 3, else 0.
- Simultaneous clear and new edge on the same bit: the bit stays 1 (edge wins, no event lost).
- Bits already 1 stay 1 on repeated edges; there is no count.
- irq = |(edge_capture & irq_mask), combinational from registers, no added latency.
  - irq deasserts the cycle after the clearing write or mask write.
- Read path:
  - readdata <= mux(address) every edge, regardless of chipselect.
  - Reads have no side effects.
  - Value is valid the cycle after the address is presented.
  - Reading addr 3 in the clearing cycle returns the pre-clear value.
- Write and read to the same address in one cycle: readdata shows the old value.
- Reset mid-operation: all state clears at once. Edges present at reset release are not captured, because prev and data_in start equal at 0.
  - A 1 on in_port at release then counts as a rising edge once it propagates (SYNC_STAGES+1 edges).
- Glitch shorter than one clk period: may be missed; no requirement to capture it.

Test Plan:
- Reset, then read addr 0/1/2/3 with in_port=0 -> readdata 0 for each; irq=0.
- SYNC_STAGES=2, EDGE_TYPE=0: in_port 0->0x0000_00A5 at edge k -> data_in=0xA5 after k+1, edge_capture=0xA5 after k+2.
  - Read addr 3 -> 0x0000_00A5.
  - With mask=0, irq stays 0.
- Write mask 0x0000_0004 with edge_capture=0xA5 -> irq=1 the cycle after the write.
  - BIT_CLEAR=1 write 0x0000_0001 to addr 3 -> edge_capture=0xA4, irq stays 1.
  - Write 0x0000_0004 -> edge_capture=0xA0, irq=0.
- Rising edge on bit 3 detected in the same cycle as a W1C of 0x8 to addr 3 -> bit 3 remains 1.
- EDGE_TYPE=1: in_port 0xFF->0x0F -> edge_capture=0xF0.
  - BIT_CLEAR=0: write any data to addr 3 -> edge_capture=0.
- Assert reset_n low mid-capture with edge_capture=0xF0, mask=0xFF, irq=1 -> all registers 0 and irq=0 asynchronously.
  - After release with in_port=0x1 held -> edge_capture=0x1 after SYNC_STAGES+1 edges.
